// File: rtl/uart_tx_sched_pkg.sv
// Shared definitions for the UART TX scheduler: reporter state codes,
// the fixed report text and the nibble-to-ASCII helper.
package uart_tx_sched_pkg;

    typedef logic [1:0] rep_state_t;

    localparam rep_state_t ST_IDLE   = 2'd0;
    localparam rep_state_t ST_PREFIX = 2'd1;
    localparam rep_state_t ST_HEX    = 2'd2;
    localparam rep_state_t ST_NL     = 2'd3;

    // First character sits in the top byte, so index i selects bits [63-8i -: 8].
    localparam logic [63:0] PREFIX_STR = "Result: ";
    localparam logic [7:0]  NEWLINE    = 8'h0A;

    // Lower-case hex digit for one nibble.
    function automatic logic [7:0] nibble_to_ascii(input logic [3:0] n);
        if (n < 4'd10) begin
            return 8'h30 + {4'h0, n};
        end
        return 8'h61 + {4'h0, n} - 8'd10;
    endfunction

endpackage

// File: rtl/uart_tx_sched_if.sv
// Bus bundle for the UART TX scheduler: CPU byte stream, CSR trigger,
// UART TX handshake and reporter status. The block itself uses the slave view.
interface uart_tx_sched_if;
    logic [7:0]  cpu_tx_data;
    logic        cpu_tx_valid;
    logic        cpu_tx_ready;
    logic        csr_we;
    logic [31:0] csr_wdata;
    logic [7:0]  uart_tx_data;
    logic        uart_tx_valid;
    logic        uart_tx_ready;
    logic        report_busy;
    logic        report_done;
    logic        report_overrun;

    modport master (
        output cpu_tx_data, cpu_tx_valid, csr_we, csr_wdata, uart_tx_ready,
        input  cpu_tx_ready, uart_tx_data, uart_tx_valid,
               report_busy, report_done, report_overrun
    );

    modport slave (
        input  cpu_tx_data, cpu_tx_valid, csr_we, csr_wdata, uart_tx_ready,
        output cpu_tx_ready, uart_tx_data, uart_tx_valid,
               report_busy, report_done, report_overrun
    );
endinterface

// File: rtl/uart_tx_sched_sync_fifo.sv
// sync_fifo: single-clock first-word-fall-through FIFO with registered
// full/empty flags. Pointers carry one extra wrap bit to tell full from empty.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] push_data,
    input  logic             push,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr, rd_ptr, wr_next, rd_next;
    logic             do_push, do_pop;

    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign wr_next  = wr_ptr + {{AW{1'b0}}, do_push};
    assign rd_next  = rd_ptr + {{AW{1'b0}}, do_pop};
    assign pop_data = mem[rd_ptr[AW-1:0]];

    // Pointer update; flags are derived from the next pointers so they come straight from flops.
    // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            wr_ptr <= wr_next;
            rd_ptr <= rd_next;
            full   <= (wr_next ^ rd_next) == {1'b1, {AW{1'b0}}};
            empty  <= wr_next == rd_next;
        end
    end

    // Storage array write port.
    // NOTE: the array is not reset; the pointers alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: shares the UART transmitter between the CPU byte stream
// (buffered in a FIFO) and a reporter that prints "Result: xxxxxxxx\n"
// whenever a non-zero value is written to the tohost CSR.
module uart_tx_sched
    import uart_tx_sched_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int REPORT_EN  = 1
) (
    input logic            clk,
    input logic            rst,
    uart_tx_sched_if.slave bus
);
    rep_state_t  state;
    logic [2:0]  idx;
    logic [31:0] value;
    logic        overrun_q;

    logic [7:0]  fifo_data;
    logic        fifo_full, fifo_empty;

    logic        out_valid;
    logic [7:0]  out_data;

    logic        rep_has;
    logic [7:0]  rep_byte;
    logic        can_load, load_rep, load_fifo, hs, nl_hs, trigger;

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push_data (bus.cpu_tx_data),
        .push      (bus.cpu_tx_valid),
        .pop       (load_fifo),
        .pop_data  (fifo_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign hs        = out_valid && bus.uart_tx_ready;
    assign can_load  = !out_valid || bus.uart_tx_ready;
    assign trigger   = (REPORT_EN != 0) && bus.csr_we && (bus.csr_wdata != '0);
    // While a report runs the FIFO never gets a grant, so CPU bytes cannot interleave.
    assign load_rep  = can_load && (state != ST_IDLE) && rep_has;
    assign load_fifo = can_load && (state == ST_IDLE) && !fifo_empty;
    // In NL, idx != 0 means the newline already sits in the output register.
    assign nl_hs     = (state == ST_NL) && (idx != 3'd0) && hs;

    // Byte the reporter offers for the current state and index.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        rep_has  = 1'b0;
        rep_byte = NEWLINE;
        case (state)
            ST_PREFIX: begin
                rep_has  = 1'b1;
                rep_byte = PREFIX_STR[{3'd7 - idx, 3'b111} -: 8];
            end
            ST_HEX: begin
                rep_has  = 1'b1;
                rep_byte = nibble_to_ascii(value[{3'd7 - idx, 2'b11} -: 4]);
            end
            ST_NL: begin
                rep_has  = (idx == 3'd0);
                rep_byte = NEWLINE;
            end
            default: begin
                rep_has  = 1'b0;
                rep_byte = NEWLINE;
            end
        endcase
    end

    // Output register: holds a byte stable until the UART takes it, reloads back-to-back.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (load_rep || load_fifo) begin
            out_valid <= 1'b1;
            out_data  <= load_rep ? rep_byte : fifo_data;
        end else if (bus.uart_tx_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Reporter sequencer; the report stays busy until the newline handshakes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            idx       <= '0;
            value     <= '0;
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= trigger && (state != ST_IDLE);
            case (state)
                ST_IDLE: begin
                    if (trigger) begin
                        value <= bus.csr_wdata;
                        idx   <= '0;
                        state <= ST_PREFIX;
                    end
                end
                ST_PREFIX: begin
                    if (load_rep) begin
                        idx <= idx + 3'd1;
                        if (idx == 3'd7) state <= ST_HEX;
                    end
                end
                ST_HEX: begin
                    if (load_rep) begin
                        idx <= idx + 3'd1;
                        if (idx == 3'd7) state <= ST_NL;
                    end
                end
                default: begin
                    if (load_rep) begin
                        idx <= 3'd1;
                    end else if (nl_hs) begin
                        idx   <= '0;
                        state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.cpu_tx_ready   = !fifo_full;
    assign bus.uart_tx_data   = out_data;
    assign bus.uart_tx_valid  = out_valid;
    assign bus.report_busy    = (state != ST_IDLE);
    assign bus.report_done    = nl_hs;
    assign bus.report_overrun = overrun_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Self-checking bench for uart_tx_sched: a queue-based model of the shared
// UART output is compared against the DUT every cycle, plus literal checks
// of the printed text, latencies and pulse counts.
`timescale 1ns/1ps
module tb_uart_tx_sched;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    uart_tx_sched_if bus();

    uart_tx_sched #(.FIFO_DEPTH(DEPTH), .REPORT_EN(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    bit chk_en = 1'b0;

    // Model state: CPU bytes waiting, the byte on the UART side, remaining report text.
    byte unsigned m_cpu_q[$];
    byte unsigned m_rep_q[$];
    bit           m_slot_v = 1'b0;
    byte unsigned m_slot_b = 8'h00;
    bit           m_slot_rep = 1'b0;
    bit           m_rep_active = 1'b0;
    bit           m_ov = 1'b0;

    // Observed UART stream and pulse counts.
    byte unsigned log_q[$];
    int done_cnt = 0;
    int ov_cnt = 0;
    int first_valid_cyc = -1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic string vis(input string s);
        string r = "";
        for (int i = 0; i < s.len(); i++) begin
            if (s[i] == 8'h0A) r = {r, "\\n"};
            else r = $sformatf("%s%c", r, s[i]);
        end
        return r;
    endfunction

    function automatic string q2str(input byte unsigned q[$]);
        string s = "";
        foreach (q[i]) s = $sformatf("%s%c", s, q[i]);
        return s;
    endfunction

    task automatic check_str(input string name, input string act, input string exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got \"%s\" expected \"%s\"", name, vis(act), vis(exp));
        end
    endtask

    // Model: advance one clock using the inputs present at the edge.
    always @(posedge clk) begin : model
        bit hs, can_load, push_ok, trig, was_active;
        string s;
        cyc++;
        if (rst) begin
            m_cpu_q.delete();
            m_rep_q.delete();
            m_slot_v = 1'b0;
            m_slot_b = 8'h00;
            m_slot_rep = 1'b0;
            m_rep_active = 1'b0;
            m_ov = 1'b0;
        end else begin
            hs = m_slot_v && bus.uart_tx_ready;
            can_load = !m_slot_v || bus.uart_tx_ready;
            push_ok = bus.cpu_tx_valid && (m_cpu_q.size() < DEPTH);
            trig = bus.csr_we && (bus.csr_wdata != 32'd0);
            was_active = m_rep_active;
            if (was_active && m_rep_q.size() == 0 && hs && m_slot_rep) m_rep_active = 1'b0;
            if (was_active && can_load && m_rep_q.size() != 0) begin
                m_slot_b = m_rep_q.pop_front();
                m_slot_v = 1'b1;
                m_slot_rep = 1'b1;
            end else if (!was_active && can_load && m_cpu_q.size() != 0) begin
                m_slot_b = m_cpu_q.pop_front();
                m_slot_v = 1'b1;
                m_slot_rep = 1'b0;
            end else if (hs) begin
                m_slot_v = 1'b0;
            end
            if (push_ok) m_cpu_q.push_back(bus.cpu_tx_data);
            m_ov = trig && was_active;
            if (trig && !was_active) begin
                s = $sformatf("Result: %08h\n", bus.csr_wdata);
                m_rep_q.delete();
                for (int i = 0; i < s.len(); i++) m_rep_q.push_back(s[i]);
                m_rep_active = 1'b1;
            end
        end
    end

    // Record what the UART actually receives.
    always @(posedge clk) begin
        if (chk_en && !rst) begin
            if (bus.uart_tx_valid && bus.uart_tx_ready) log_q.push_back(bus.uart_tx_data);
            if (bus.report_done) done_cnt++;
            if (bus.report_overrun) ov_cnt++;
        end
    end

    // Per-cycle comparison against the model, mid-cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            check("uart_tx_valid", bus.uart_tx_valid, m_slot_v);
            if (m_slot_v) check("uart_tx_data", bus.uart_tx_data, m_slot_b);
            check("cpu_tx_ready", bus.cpu_tx_ready, m_cpu_q.size() < DEPTH);
            check("report_busy", bus.report_busy, m_rep_active);
            check("report_done", bus.report_done,
                  m_rep_active && m_rep_q.size() == 0 && m_slot_v && m_slot_rep && bus.uart_tx_ready);
            check("report_overrun", bus.report_overrun, m_ov);
            if (first_valid_cyc < 0 && bus.uart_tx_valid) first_valid_cyc = cyc;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic clear_log();
        log_q.delete();
        done_cnt = 0;
        ov_cnt = 0;
        first_valid_cyc = -1;
    endtask

    task automatic trigger(input logic [31:0] v);
        bus.csr_we = 1'b1;
        bus.csr_wdata = v;
        tick();
        bus.csr_we = 1'b0;
        bus.csr_wdata = 32'd0;
    endtask

    task automatic push(input byte unsigned b);
        int k = 0;
        while (!bus.cpu_tx_ready && k < 100) begin
            tick();
            k++;
        end
        check("push_timeout", k >= 100, 0);
        bus.cpu_tx_valid = 1'b1;
        bus.cpu_tx_data = b;
        tick();
        bus.cpu_tx_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int k = 0;
        while (k < 400 && (bus.uart_tx_valid || bus.report_busy ||
                           m_cpu_q.size() != 0 || m_slot_v || m_rep_active)) begin
            tick();
            k++;
        end
        ticks(2);
        check({name, "_timeout"}, k >= 400, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int start_cyc, acc, k;
        bus.cpu_tx_valid = 1'b0;
        bus.cpu_tx_data = 8'h00;
        bus.csr_we = 1'b0;
        bus.csr_wdata = 32'd0;
        bus.uart_tx_ready = 1'b1;

        // Reset state.
        rst = 1'b1;
        tick();
        chk_en = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_valid", bus.uart_tx_valid, 0);
        check("rst_data", bus.uart_tx_data, 0);
        check("rst_cpu_ready", bus.cpu_tx_ready, 1);
        check("rst_busy", bus.report_busy, 0);
        check("rst_done", bus.report_done, 0);
        check("rst_overrun", bus.report_overrun, 0);

        // CPU bytes straight through, one per cycle.
        clear_log();
        start_cyc = cyc;
        bus.cpu_tx_valid = 1'b1;
        bus.cpu_tx_data = 8'h48;
        tick();
        bus.cpu_tx_data = 8'h69;
        tick();
        bus.cpu_tx_data = 8'h0A;
        tick();
        bus.cpu_tx_valid = 1'b0;
        wait_idle("t1");
        check("t1_latency", first_valid_cyc - start_cyc, 2);
        check_str("t1_bytes", q2str(log_q), "Hi\n");

        // Standalone report.
        clear_log();
        start_cyc = cyc;
        trigger(32'hdeadbeef);
        wait_idle("t2");
        check("t2_latency", first_valid_cyc - start_cyc, 2);
        check_str("t2_report", q2str(log_q), "Result: deadbeef\n");
        check("t2_done_cnt", done_cnt, 1);
        check("t2_overrun_cnt", ov_cnt, 0);

        // Report lands between CPU bytes once 'A' is on the UART side.
        clear_log();
        bus.uart_tx_ready = 1'b0;
        push(8'h41);
        push(8'h42);
        push(8'h43);
        push(8'h44);
        k = 0;
        while (!bus.uart_tx_valid && k < 20) begin
            tick();
            k++;
        end
        check("t3_valid_timeout", k >= 20, 0);
        trigger(32'h00001a2f);
        bus.uart_tx_ready = 1'b1;
        wait_idle("t3");
        check_str("t3_interleave", q2str(log_q), "AResult: 00001a2f\nBCD");
        check("t3_done_cnt", done_cnt, 1);

        // Back-pressure: FIFO plus output register fill, then drain in order.
        clear_log();
        bus.uart_tx_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < DEPTH + 2; i++) begin
            if (!bus.cpu_tx_ready) break;
            bus.cpu_tx_valid = 1'b1;
            bus.cpu_tx_data = 8'h30 + 8'(i);
            tick();
            acc++;
        end
        // The first byte moves into the output register, so one more than the FIFO depth fits.
        check("t4_accepted", acc, DEPTH + 1);
        check("t4_ready_low", bus.cpu_tx_ready, 0);
        bus.cpu_tx_data = 8'h30 + 8'(acc);
        ticks(4);
        check("t4_hold_data", bus.uart_tx_data, 8'h30);
        bus.uart_tx_ready = 1'b1;
        k = 0;
        while (!bus.cpu_tx_ready && k < 20) begin
            tick();
            k++;
        end
        check("t4_ready_timeout", k >= 20, 0);
        tick();
        bus.cpu_tx_valid = 1'b0;
        wait_idle("t4");
        check_str("t4_order", q2str(log_q), "0123456789");

        // Second trigger during a report is dropped; zero write is ignored.
        clear_log();
        trigger(32'hcafe0042);
        ticks(5);
        trigger(32'h00001234);
        wait_idle("t5");
        check_str("t5_report", q2str(log_q), "Result: cafe0042\n");
        check("t5_overrun_cnt", ov_cnt, 1);
        check("t5_done_cnt", done_cnt, 1);
        clear_log();
        trigger(32'd0);
        ticks(10);
        check("t5_zero_bytes", log_q.size(), 0);
        check("t5_zero_busy", bus.report_busy, 0);
        check("t5_zero_overrun_cnt", ov_cnt, 0);

        // Reset in the middle of a report, then a fresh report.
        clear_log();
        trigger(32'hfeedface);
        k = 0;
        while (log_q.size() < 4 && k < 50) begin
            tick();
            k++;
        end
        check("t6_wait_timeout", k >= 50, 0);
        rst = 1'b1;
        tick();
        check("t6_rst_valid", bus.uart_tx_valid, 0);
        check("t6_rst_busy", bus.report_busy, 0);
        check("t6_rst_done", bus.report_done, 0);
        rst = 1'b0;
        tick();
        check("t6_done_after_rst", done_cnt, 0);
        clear_log();
        trigger(32'h00000001);
        wait_idle("t6");
        check_str("t6_report", q2str(log_q), "Result: 00000001\n");
        check("t6_done_cnt", done_cnt, 1);

        // Randomised traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            bus.cpu_tx_valid = ($urandom_range(0, 99) < 50);
            bus.cpu_tx_data = 8'($urandom);
            bus.uart_tx_ready = ($urandom_range(0, 99) < 70);
            bus.csr_we = ($urandom_range(0, 99) < 3);
            bus.csr_wdata = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom);
            rst = ($urandom_range(0, 999) < 3);
            tick();
        end
        rst = 1'b0;
        bus.cpu_tx_valid = 1'b0;
        bus.csr_we = 1'b0;
        bus.csr_wdata = 32'd0;
        bus.uart_tx_ready = 1'b1;
        wait_idle("rand");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
